// File: rtl/usb_crc_pkg.sv
// Shared types and USB CRC constants for the serial CRC engine family.
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        SHIFT_OUT = 2'd2
    } crc_state_t;

    localparam logic [4:0]  CRC5_POLY     = 5'h05;
    localparam logic [4:0]  CRC5_INIT     = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial LFSR step: folds a single data bit into the CRC register.
module crc_lfsr_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] crc_i,
    input  logic         bit_i,
    input  logic [W-1:0] poly_i,
    output logic [W-1:0] crc_o
);

    logic fb_s;

    assign fb_s  = bit_i ^ crc_i[W-1];
    assign crc_o = {crc_i[W-2:0], 1'b0} ^ (fb_s ? poly_i : {W{1'b0}});

endmodule

// File: rtl/crc_engine.sv
// Serial CRC engine: accumulates an unstuffed bit stream, checks the residue
// and serialises the (optionally inverted) CRC MSB-first under ready pacing.
module crc_engine
    import usb_crc_pkg::*;
#(
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(CRC16_POLY),
    parameter logic [CRC_WIDTH-1:0] INIT       = {CRC_WIDTH{1'b1}},
    parameter logic [CRC_WIDTH-1:0] RESIDUE    = CRC_WIDTH'(CRC16_RESIDUE),
    parameter bit                   OUT_INVERT = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 stuff_bit,
    input  logic                 gen_req,
    input  logic                 out_ready,
    output logic                 crc_bit_out,
    output logic                 crc_bit_valid,
    output logic                 done,
    output logic                 busy,
    output logic [CRC_WIDTH-1:0] crc_value,
    output logic                 residue_ok
);

    localparam int             MSB      = CRC_WIDTH - 1;
    localparam int             CW       = $clog2(CRC_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CRC_WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    crc_state_t           state_q;
    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_step_d;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 bit_valid_q;
    logic                 accept_s;

    assign accept_s = bit_valid && !stuff_bit;

    crc_lfsr_step #(.W(CRC_WIDTH)) u_step (
        .crc_i  (crc_q),
        .bit_i  (bit_in),
        .poly_i (POLY),
        .crc_o  (crc_step_d)
    );

    // Control FSM, shift counter, CRC register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= {CW{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    // A bit arriving with gen_req is folded in before shift-out starts.
                    if (accept_s) begin
                        crc_q <= crc_step_d;
                    end
                    if (gen_req) begin
                        state_q     <= SHIFT_OUT;
                        cnt_q       <= {CW{1'b0}};
                        busy_q      <= 1'b1;
                        bit_valid_q <= 1'b1;
                    end else if (accept_s) begin
                        state_q     <= ACCUM;
                        busy_q      <= 1'b1;
                        bit_valid_q <= 1'b0;
                    end
                end
                SHIFT_OUT: begin
                    if (out_ready) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= IDLE;
                            crc_q       <= INIT;
                            cnt_q       <= {CW{1'b0}};
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            bit_valid_q <= 1'b0;
                        end else begin
                            crc_q <= {crc_q[MSB-1:0], 1'b0};
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    crc_q       <= INIT;
                    cnt_q       <= {CW{1'b0}};
                    busy_q      <= 1'b0;
                    bit_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign crc_bit_out   = crc_q[MSB] ^ OUT_INVERT;
    assign crc_bit_valid = bit_valid_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign crc_value     = OUT_INVERT ? ~crc_q : crc_q;
    assign residue_ok    = (crc_q == RESIDUE);

endmodule
